// File: rtl/ft_recovery_unit_if.sv
// rtl/ft_recovery_unit_if.sv - safe-memory read port (req/gnt/rvalid) between ft_recovery_unit and ft_memory
// Purpose : bundles the checkpoint read channel so the recovery unit and the memory
//           model/controller share one definition of the handshake.
// Signals : data_req_o, data_addr_o       driven by the recovery unit (master)
//           data_gnt_i, data_rvalid_i,
//           data_err_i, data_rdata_i      driven by the safe memory (slave)
interface ft_recovery_unit_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  data_req_o;
   logic [31:0]           data_addr_o;
   logic                  data_gnt_i;
   logic                  data_rvalid_i;
   logic                  data_err_i;
   logic [DATA_WIDTH-1:0] data_rdata_i;

   modport master (
      output data_req_o,
      output data_addr_o,
      input  data_gnt_i,
      input  data_rvalid_i,
      input  data_err_i,
      input  data_rdata_i
   );

   modport slave (
      input  data_req_o,
      input  data_addr_o,
      output data_gnt_i,
      output data_rvalid_i,
      output data_err_i,
      output data_rdata_i
   );
endinterface

// File: rtl/ft_recovery_unit.sv
// rtl/ft_recovery_unit.sv - replays a checkpoint (x1..x(NUM_REGS-1), then PC) from safe memory into both cores
// Purpose : on recover_i, reads each checkpointed GPR and finally the PC word over the
//           req/gnt/rvalid port, issues one register-file write per GPR, one PC load,
//           then pulses done_o. A read error parks the unit in ERROR with err_o sticky.
// Ports   : clk_i, rst_ni (synchronous, active-low), recover_i
//           mem        ft_recovery_unit_if.master - checkpoint read channel
//           rf_we_o, rf_addr_o, rf_wdata_o        - GPR restore write
//           pc_load_o, pc_o                       - PC restore
//           busy_o, done_o, err_o                 - status
// Option  : FT_RECOVERY_TIMEOUT_EN adds a watchdog of TIMEOUT cycles on gnt (REQ) and
//           rvalid (WAIT) that sends the unit to ERROR; without it REQ/WAIT wait forever.
module ft_recovery_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int PC_BYTE    = 128,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  recover_i,
   ft_recovery_unit_if.master    mem,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_addr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  pc_load_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);
   localparam int IDX_W = $clog2(NUM_REGS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [ADDR_WIDTH-1:0] rf_addr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic                  err_q;
   logic                  idx_is_gpr;
   logic                  timed_out;

   // idx walks 1..NUM_REGS; the final value addresses the PC word instead of a GPR.
   assign idx_is_gpr = (idx_q < IDX_W'(NUM_REGS));

`ifdef FT_RECOVERY_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt_q;

   // Counts cycles already spent in the current REQ/WAIT; on the TIMEOUT-th cycle
   // without the awaited event the FSM leaves for ERROR.
   assign timed_out = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wd_cnt_q <= '0;
      end else if (state_d != state_q) begin
         wd_cnt_q <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
         wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end
   end
`else
   // TIMEOUT only matters when the watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timed_out      = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      mem.data_req_o  = 1'b0;
      mem.data_addr_o = '0;
      rf_we_o         = 1'b0;
      pc_load_o       = 1'b0;
      done_o          = 1'b0;
      busy_o          = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (recover_i) state_d = S_REQ;
         end
         S_REQ: begin
            mem.data_req_o  = 1'b1;
            mem.data_addr_o = idx_is_gpr ? (32'(idx_q) << 2) : 32'(PC_BYTE);
            // rvalid is deliberately not looked at here: data may only follow gnt.
            if (mem.data_gnt_i)  state_d = S_WAIT;
            else if (timed_out)  state_d = S_ERROR;
         end
         S_WAIT: begin
            if (mem.data_rvalid_i) state_d = mem.data_err_i ? S_ERROR : S_WRITE;
            else if (timed_out)    state_d = S_ERROR;
         end
         S_WRITE: begin
            rf_we_o   = idx_is_gpr;
            pc_load_o = ~idx_is_gpr;
            state_d   = idx_is_gpr ? S_REQ : S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         S_ERROR: begin
            busy_o = 1'b0;
            if (recover_i) state_d = S_REQ;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Restore data is captured straight into the output holding registers on the
   // accepting rvalid, so it is already stable during the WRITE strobe and keeps
   // its value afterwards.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         idx_q      <= IDX_W'(1);
         rf_addr_q  <= '0;
         rf_wdata_q <= '0;
         pc_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         if ((state_q == S_IDLE || state_q == S_ERROR) && recover_i) begin
            idx_q <= IDX_W'(1);
            err_q <= 1'b0;
         end
         if (state_q == S_WAIT && state_d == S_WRITE) begin
            if (idx_is_gpr) begin
               rf_addr_q  <= idx_q[ADDR_WIDTH-1:0];
               rf_wdata_q <= mem.data_rdata_i;
            end else begin
               pc_q <= mem.data_rdata_i;
            end
         end
         if (state_q == S_WRITE && idx_is_gpr) begin
            idx_q <= idx_q + IDX_W'(1);
         end
         if (state_q != S_ERROR && state_d == S_ERROR) begin
            err_q <= 1'b1;
         end
      end
   end

   assign rf_addr_o  = rf_addr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign pc_o       = pc_q;
   assign err_o      = err_q;
endmodule
